// File: rtl/l1_trigger_pkg.sv
// Shared definitions for the L1 trigger hold-off block: event word layout,
// timestamp width and the FSM state type.
package l1_trigger_pkg;

  localparam int TS_W     = 32;
  localparam int BEAM_W   = 32;
  localparam int WORD_W   = 64;
  localparam int BEAM_LSB = 0;
  localparam int TS_LSB   = 32;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_HOLDOFF = 1'b1
  } state_t;

  function automatic logic [WORD_W-1:0] pack_event(input logic [TS_W-1:0]   ts,
                                                   input logic [BEAM_W-1:0] beams);
    logic [WORD_W-1:0] word;
    word                      = '0;
    word[TS_LSB +: TS_W]      = ts;
    word[BEAM_LSB +: BEAM_W]  = beams;
    return word;
  endfunction

endpackage

// File: rtl/l1_event_fifo.sv
// Synchronous event FIFO: array storage with a registered output stage.
// Occupancy (and so full/empty) includes the word held in the output register.
module l1_event_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic             aclk,
  input  logic             reset_i,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_reg;
  logic [AW-1:0]    rptr_reg;
  logic [AW:0]      mem_cnt_reg;
  logic [WIDTH-1:0] rd_data_reg;
  logic             rd_valid_reg;
  logic [AW:0]      occ;
  logic             wr_accept;
  logic             pop;
  logic             load;

  assign occ       = mem_cnt_reg + (AW+1)'(rd_valid_reg);
  assign full      = (occ == (AW+1)'(DEPTH));
  assign empty     = (occ == '0);
  // Full is judged before any same-cycle pop, so a write at full is refused.
  assign wr_accept = wr_en & ~full;
  assign pop       = rd_valid_reg & rd_ready;
  assign load      = (mem_cnt_reg != '0) && (!rd_valid_reg || rd_ready);

  assign rd_data   = rd_data_reg;
  assign rd_valid  = rd_valid_reg;

  always_ff @(posedge aclk) begin
    if (wr_accept) begin
      mem[wptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge aclk or posedge reset_i) begin
    if (reset_i) begin
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      mem_cnt_reg  <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      if (wr_accept) begin
        wptr_reg <= wptr_reg + AW'(1);
      end
      if (load) begin
        rd_data_reg  <= mem[rptr_reg];
        rptr_reg     <= rptr_reg + AW'(1);
        rd_valid_reg <= 1'b1;
      end else if (pop) begin
        rd_valid_reg <= 1'b0;
      end
      case ({wr_accept, load})
        2'b10:   mem_cnt_reg <= mem_cnt_reg + (AW+1)'(1);
        2'b01:   mem_cnt_reg <= mem_cnt_reg - (AW+1)'(1);
        default: mem_cnt_reg <= mem_cnt_reg;
      endcase
    end
  end

endmodule

// File: rtl/l1_trigger_holdoff.sv
// L1 trigger with dead time: qualifies registered beam triggers, timestamps
// the event, queues it in a FIFO and ignores triggers for holdoff_i+1 cycles.
module l1_trigger_holdoff
  import l1_trigger_pkg::*;
#(
  parameter int NBEAMS     = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              aclk,
  input  logic              reset_i,
  input  logic [NBEAMS-1:0] trigger_i,
  input  logic [NBEAMS-1:0] mask_i,
  input  logic              enable_i,
  input  logic [15:0]       holdoff_i,
  output logic [63:0]       m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              busy_o,
  output logic [31:0]       event_count_o,
  output logic [15:0]       drop_count_o
);

  logic [TS_W-1:0]   ts_reg;
  logic [NBEAMS-1:0] s1_trig_reg;
  logic [TS_W-1:0]   s1_ts_reg;
  state_t            state_reg, state_next;
  logic [15:0]       cnt_reg, cnt_next;
  logic [WORD_W-1:0] ev_word_reg;
  logic              wr_pend_reg;
  logic [31:0]       event_count_reg;
  logic [15:0]       drop_count_reg;

  logic [NBEAMS-1:0] hit;
  logic [BEAM_W-1:0] beam_bits;
  logic              accept;
  logic              fifo_full;
  logic              fifo_empty;
  logic              write_ok;
  logic              write_drop;

  assign hit = s1_trig_reg & ~mask_i;

  generate
    for (genvar gi = 0; gi < BEAM_W; gi++) begin : g_beam
      if (gi < NBEAMS) begin : g_used
        assign beam_bits[gi] = hit[gi];
      end else begin : g_pad
        assign beam_bits[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (enable_i && (|hit)) begin
          state_next = ST_HOLDOFF;
          cnt_next   = holdoff_i;
          accept     = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_reg == 16'd0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A full FIFO implies a non-empty one; both flags gate the drop path.
  assign write_ok   = wr_pend_reg & ~fifo_full;
  assign write_drop = wr_pend_reg & fifo_full & ~fifo_empty;

  always_ff @(posedge aclk or posedge reset_i) begin
    if (reset_i) begin
      ts_reg          <= '0;
      s1_trig_reg     <= '0;
      s1_ts_reg       <= '0;
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      ev_word_reg     <= '0;
      wr_pend_reg     <= 1'b0;
      event_count_reg <= '0;
      drop_count_reg  <= '0;
    end else begin
      ts_reg      <= ts_reg + 32'd1;
      s1_trig_reg <= trigger_i;
      s1_ts_reg   <= ts_reg;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      wr_pend_reg <= accept;
      if (accept) begin
        ev_word_reg <= pack_event(s1_ts_reg, beam_bits);
      end
      if (write_ok) begin
        event_count_reg <= event_count_reg + 32'd1;
      end
      if (write_drop && (drop_count_reg != 16'hFFFF)) begin
        drop_count_reg <= drop_count_reg + 16'd1;
      end
    end
  end

  l1_event_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk     (aclk),
    .reset_i  (reset_i),
    .wr_en    (wr_pend_reg),
    .wr_data  (ev_word_reg),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .rd_data  (m_tdata),
    .rd_valid (m_tvalid),
    .rd_ready (m_tready)
  );

  assign busy_o        = (state_reg == ST_HOLDOFF);
  assign event_count_o = event_count_reg;
  assign drop_count_o  = drop_count_reg;

endmodule

// File: tb/tb_l1_trigger_holdoff.sv
// Directed bench for l1_trigger_holdoff: each scenario task drives stimulus
// on the falling edge and compares outputs against hand-derived values.
module tb_l1_trigger_holdoff;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  trigger;
  logic [1:0]  mask;
  logic        enable;
  logic [15:0] holdoff;
  logic        ready;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        busy;
  logic [31:0] event_count;
  logic [15:0] drop_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] cyc;
  logic [63:0] got_q [$];

  always #5 clk = ~clk;

  l1_trigger_holdoff #(.NBEAMS(2), .FIFO_DEPTH(16)) dut (
    .aclk          (clk),
    .reset_i       (rst),
    .trigger_i     (trigger),
    .mask_i        (mask),
    .enable_i      (enable),
    .holdoff_i     (holdoff),
    .m_tdata       (m_tdata),
    .m_tvalid      (m_tvalid),
    .m_tready      (ready),
    .busy_o        (busy),
    .event_count_o (event_count),
    .drop_count_o  (drop_count)
  );

  // Cycle count since reset release: equals the timestamp at each falling edge.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 32'd0;
    else     cyc <= cyc + 32'd1;
  end

  always @(posedge clk) begin
    if (!rst && m_tvalid && ready) begin
      got_q.push_back(m_tdata);
      $display("word ts=%08h beams=%08h", m_tdata[63:32], m_tdata[31:0]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [1:0] t);
    trigger = t;
    tick(1);
    trigger = 2'b00;
  endtask

  task automatic test_reset;
    rst = 1'b1; trigger = 2'b00; mask = 2'b00; enable = 1'b1;
    holdoff = 16'd0; ready = 1'b1;
    tick(3);
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b want=0", m_tvalid); end
    checks++; if (m_tdata !== 64'd0) begin failures++; $display("FAIL reset_tdata got=%h want=0", m_tdata); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (event_count !== 32'd0) begin failures++; $display("FAIL reset_evcnt got=%0d want=0", event_count); end
    checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL reset_dropcnt got=%0d want=0", drop_count); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_single;
    logic [31:0] exp_ts;
    int busy_cnt;
    got_q.delete();
    holdoff = 16'd10;
    exp_ts  = cyc;
    pulse(2'b01);
    busy_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (i == 2) begin
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b want=0", m_tvalid); end
      end
      if (i == 3) begin
        checks++; if (m_tvalid !== 1'b1) begin failures++; $display("FAIL single_latency got=%b want=1", m_tvalid); end
        checks++; if (m_tdata !== {exp_ts, 32'h1}) begin failures++; $display("FAIL single_word got=%h want=%h", m_tdata, {exp_ts, 32'h1}); end
      end
      if (busy === 1'b1) busy_cnt++;
    end
    checks++; if (busy_cnt != 11) begin failures++; $display("FAIL single_busy_len got=%0d want=11", busy_cnt); end
    checks++; if (event_count !== 32'd1) begin failures++; $display("FAIL single_evcnt got=%0d want=1", event_count); end
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL single_nwords got=%0d want=1", got_q.size()); end
  endtask

  task automatic test_periodic;
    logic [31:0] t0;
    got_q.delete();
    holdoff = 16'd20;
    t0 = cyc;
    for (int j = 0; j < 100; j++) begin
      trigger = (j % 4 == 0) ? 2'b10 : 2'b00;
      tick(1);
      if (j % 24 == 23) begin
        checks++;
        if (event_count !== 32'(2 + j / 24)) begin
          failures++; $display("FAIL periodic_window_cnt j=%0d got=%0d want=%0d", j, event_count, 2 + j / 24);
        end
      end
    end
    trigger = 2'b00;
    tick(30);
    checks++; if (event_count !== 32'd6) begin failures++; $display("FAIL periodic_evcnt got=%0d want=6", event_count); end
    checks++; if (got_q.size() != 5) begin failures++; $display("FAIL periodic_nwords got=%0d want=5", got_q.size()); end
    for (int m = 0; m < got_q.size() && m < 5; m++) begin
      checks++;
      if (got_q[m] !== {t0 + 32'(24 * m), 32'h2}) begin
        failures++; $display("FAIL periodic_word%0d got=%h want=%h", m, got_q[m], {t0 + 32'(24 * m), 32'h2});
      end
    end
  endtask

  task automatic test_mask;
    logic [31:0] exp_ts;
    got_q.delete();
    holdoff = 16'd2;
    mask    = 2'b10;
    pulse(2'b10);
    tick(8);
    checks++; if (event_count !== 32'd6) begin failures++; $display("FAIL mask_blocked got=%0d want=6", event_count); end
    enable = 1'b0;
    pulse(2'b01);
    tick(8);
    checks++; if (event_count !== 32'd6) begin failures++; $display("FAIL disable_blocked got=%0d want=6", event_count); end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL mask_nwords got=%0d want=0", got_q.size()); end
    enable = 1'b1;
    exp_ts = cyc;
    pulse(2'b11);
    tick(10);
    checks++; if (event_count !== 32'd7) begin failures++; $display("FAIL mask_pass_cnt got=%0d want=7", event_count); end
    checks++;
    if (got_q.size() != 1) begin
      failures++; $display("FAIL mask_pass_nwords got=%0d want=1", got_q.size());
    end else if (got_q[0] !== {exp_ts, 32'h1}) begin
      failures++; $display("FAIL mask_pass_word got=%h want=%h", got_q[0], {exp_ts, 32'h1});
    end
    mask = 2'b00;
  endtask

  task automatic test_fill;
    logic [31:0] t0;
    got_q.delete();
    ready   = 1'b0;
    holdoff = 16'd0;
    t0      = cyc;
    trigger = 2'b01;
    tick(39);
    trigger = 2'b00;
    tick(6);
    checks++; if (event_count !== 32'd23) begin failures++; $display("FAIL fill_evcnt got=%0d want=23", event_count); end
    checks++; if (drop_count !== 16'd4) begin failures++; $display("FAIL fill_dropcnt got=%0d want=4", drop_count); end
    checks++; if (m_tvalid !== 1'b1) begin failures++; $display("FAIL fill_valid got=%b want=1", m_tvalid); end
    tick(3);
    checks++; if (m_tdata !== {t0, 32'h1}) begin failures++; $display("FAIL fill_hold_word got=%h want=%h", m_tdata, {t0, 32'h1}); end
    ready = 1'b1;
    tick(20);
    checks++; if (got_q.size() != 16) begin failures++; $display("FAIL fill_nwords got=%0d want=16", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 16; i++) begin
      checks++;
      if (got_q[i] !== {t0 + 32'(2 * i), 32'h1}) begin
        failures++; $display("FAIL fill_word%0d got=%h want=%h", i, got_q[i], {t0 + 32'(2 * i), 32'h1});
      end
    end
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL fill_drained got=%b want=0", m_tvalid); end
  endtask

  task automatic test_wrap;
    got_q.delete();
    ready   = 1'b1;
    holdoff = 16'd0;
    force dut.ts_reg = 32'hFFFF_FFFD;
    #1;
    release dut.ts_reg;
    tick(2);
    trigger = 2'b01;
    tick(3);
    trigger = 2'b00;
    tick(8);
    checks++;
    if (got_q.size() != 2) begin
      failures++; $display("FAIL wrap_nwords got=%0d want=2", got_q.size());
    end else begin
      if (got_q[0] !== {32'hFFFF_FFFF, 32'h1}) begin
        failures++; $display("FAIL wrap_word0 got=%h want=%h", got_q[0], {32'hFFFF_FFFF, 32'h1});
      end
      checks++;
      if (got_q[1] !== {32'h0000_0001, 32'h1}) begin
        failures++; $display("FAIL wrap_word1 got=%h want=%h", got_q[1], {32'h0000_0001, 32'h1});
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] exp_ts;
    int stray;
    got_q.delete();
    ready   = 1'b0;
    holdoff = 16'd0;
    pulse(2'b01);
    tick(4);
    pulse(2'b01);
    tick(4);
    holdoff = 16'd40;
    pulse(2'b01);
    tick(6);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b want=1", busy); end
    checks++; if (event_count !== 32'd28) begin failures++; $display("FAIL mid_evcnt got=%0d want=28", event_count); end
    rst = 1'b1;
    #2;
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL rstmid_tvalid got=%b want=0", m_tvalid); end
    checks++; if (m_tdata !== 64'd0) begin failures++; $display("FAIL rstmid_tdata got=%h want=0", m_tdata); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    checks++; if (event_count !== 32'd0) begin failures++; $display("FAIL rstmid_evcnt got=%0d want=0", event_count); end
    checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL rstmid_dropcnt got=%0d want=0", drop_count); end
    tick(2);
    rst   = 1'b0;
    ready = 1'b1;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (m_tvalid !== 1'b0) stray++;
    end
    checks++; if (stray != 0) begin failures++; $display("FAIL rstmid_stale_valid cycles=%0d want=0", stray); end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL rstmid_stale_words got=%0d want=0", got_q.size()); end
    exp_ts = cyc;
    pulse(2'b01);
    tick(6);
    checks++; if (event_count !== 32'd1) begin failures++; $display("FAIL rstmid_new_cnt got=%0d want=1", event_count); end
    checks++;
    if (got_q.size() != 1) begin
      failures++; $display("FAIL rstmid_new_nwords got=%0d want=1", got_q.size());
    end else if (got_q[0] !== {exp_ts, 32'h1}) begin
      failures++; $display("FAIL rstmid_new_word got=%h want=%h", got_q[0], {exp_ts, 32'h1});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_periodic();
    test_mask();
    test_fill();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
